// File: rtl/pipeline_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl_if
//
// Purpose: bundles the hazard-detection inputs, the data-memory handshake and
// the pipeline-register control outputs of pipeline_stall_ctrl into one
// interface.
//
// Signals:
//   id_ex_mem_read           instruction in EX is a load
//   id_ex_rt [4:0]           load destination register in EX
//   if_id_rs, if_id_rt [4:0] source registers of the instruction in ID
//   branch_taken             branch resolved taken in ID
//   dmem_req                 instruction in MEM accesses data memory
//   dmem_ready               data memory has completed the access
//   pc_write .. mem_wb_write pipeline register load enables
//   if_id_flush, id_ex_flush load a bubble into IF/ID or ID/EX
//   bus_err                  sticky memory-timeout error
//   stall_cycles [CNT_W-1:0] stall cycle count
//
// Modports:
//   master : the pipeline side; drives hazard/memory status, reads controls
//   slave  : the stall controller; reads status, drives controls
// ---------------------------------------------------------------------------
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_ex_mem_read;
    logic [4:0]       id_ex_rt;
    logic [4:0]       if_id_rs;
    logic [4:0]       if_id_rt;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_write;
    logic             ex_mem_write;
    logic             mem_wb_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             bus_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt,
               branch_taken, dmem_req, dmem_ready,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
               if_id_flush, id_ex_flush, bus_err, stall_cycles
    );

    modport slave (
        input  id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt,
               branch_taken, dmem_req, dmem_ready,
        output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
               if_id_flush, id_ex_flush, bus_err, stall_cycles
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Purpose: central stall/flush controller of a 5-stage in-order pipeline.
// Arbitrates three sources of disturbance, highest priority first:
//   1. data-memory wait (freeze the whole pipeline),
//   2. load-use hazard  (hold PC and IF/ID, inject a bubble into ID/EX),
//   3. taken branch     (squash the instruction in IF/ID).
// A memory access that stays unanswered for MAX_WAIT consecutive cycles
// moves the block into a sticky ERROR state that only reset leaves.
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : asynchronous reset, active low
//   bus  : pipeline_stall_ctrl_if.slave (hazard inputs, memory handshake,
//          write enables, flushes, bus_err, stall_cycles)
//
// Parameters:
//   CNT_W    : width of the stall cycle counter
//   MAX_WAIT : consecutive memory wait cycles tolerated before ERROR
//
// Configuration macro:
//   STALL_CNT_EN : when defined, stall_cycles counts cycles with pc_write=0
//                  outside ERROR, saturating at all-ones. When undefined,
//                  stall_cycles is tied to zero and no counter exists.
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_stall_ctrl_if.slave bus
);

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_WAIT  = 2'b01;
    localparam logic [1:0] ST_ERROR = 2'b10;

    // wait_cnt holds the number of consecutive stalled memory cycles so far,
    // so it only has to reach MAX_WAIT.
    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((MAX_WAIT > 1) ? MAX_WAIT - 1 : 0);
    // With MAX_WAIT <= 1 the very first stalled cycle already exhausts the
    // budget, so RUN goes straight to ERROR.
    localparam bit ERR_ON_FIRST = (MAX_WAIT <= 1);

    logic [1:0]        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic hazard;
    logic mem_stall;
    logic pc_w, ifid_w, idex_w, exmem_w, memwb_w;
    logic ifid_fl, idex_fl;

    assign hazard = bus.id_ex_mem_read && (bus.id_ex_rt != 5'd0) &&
                    ((bus.id_ex_rt == bus.if_id_rs) || (bus.id_ex_rt == bus.if_id_rt));

    // In MEM_WAIT a dropped request counts as a completed access, which is
    // exactly what this expression yields, so one term serves both states.
    assign mem_stall = bus.dmem_req && !bus.dmem_ready;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pc_w       = 1'b0;
        ifid_w     = 1'b0;
        idex_w     = 1'b0;
        exmem_w    = 1'b0;
        memwb_w    = 1'b0;
        ifid_fl    = 1'b0;
        idex_fl    = 1'b0;

        case (state_q)
            ST_RUN, ST_WAIT: begin
                if (mem_stall) begin
                    // Freeze everything; no bubbles while memory is pending.
                    if (state_q == ST_RUN) begin
                        wait_cnt_d = WAIT_ONE;
                        state_d    = ERR_ON_FIRST ? ST_ERROR : ST_WAIT;
                    end else if (wait_cnt_q >= WAIT_LAST) begin
                        state_d = ST_ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_ONE;
                    end
                end else begin
                    // Ready wins over a coinciding timeout: the access
                    // completed, so return to RUN and act on current inputs.
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                    pc_w       = 1'b1;
                    ifid_w     = 1'b1;
                    idex_w     = 1'b1;
                    exmem_w    = 1'b1;
                    memwb_w    = 1'b1;
                    if (hazard) begin
                        // Hold the dependent instruction in ID one cycle and
                        // let the load advance with a bubble behind it. A
                        // branch in ID is not remembered; ID re-presents it.
                        pc_w    = 1'b0;
                        ifid_w  = 1'b0;
                        idex_fl = 1'b1;
                    end else if (bus.branch_taken) begin
                        ifid_fl = 1'b1;
                    end
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // The enables are Mealy outputs; gating with rst makes them drop the
    // moment reset is asserted, without waiting for a clock edge.
    assign bus.pc_write     = rst & pc_w;
    assign bus.if_id_write  = rst & ifid_w;
    assign bus.id_ex_write  = rst & idex_w;
    assign bus.ex_mem_write = rst & exmem_w;
    assign bus.mem_wb_write = rst & memwb_w;
    assign bus.if_id_flush  = rst & ifid_fl;
    assign bus.id_ex_flush  = rst & idex_fl;
    assign bus.bus_err      = (state_q == ST_ERROR);

`ifdef STALL_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_w && (state_q != ST_ERROR)) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cycles = stall_cnt_q;
`else
    assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//
// Self-checking bench for pipeline_stall_ctrl: a vector table, hand-written
// multi-cycle sequences, and randomized stimulus compared with a behavioural
// model that counts consecutive memory-stall cycles.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

    localparam int MW = 15;

    typedef struct {
        logic       mr;
        logic [4:0] ex_rt;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       req;
        logic       rdy;
    } vin_t;

    typedef struct {
        vin_t       in;
        logic [6:0] exp;   // {pc, if_id_w, id_ex_w, ex_mem_w, mem_wb_w, if_id_fl, id_ex_fl}
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_stall_ctrl_if #(.CNT_W(16)) bus ();

    pipeline_stall_ctrl #(.CNT_W(16), .MAX_WAIT(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    int          m_wait = 0;   // consecutive stalled memory cycles
    bit          m_err  = 1'b0;
    logic [15:0] m_cnt  = '0;

    function automatic vin_t mk(input logic mr, input logic [4:0] ex_rt,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic br, input logic req, input logic rdy);
        vin_t v;
        v.mr = mr; v.ex_rt = ex_rt; v.rs = rs; v.rt = rt;
        v.br = br; v.req = req; v.rdy = rdy;
        return v;
    endfunction

    function automatic bit is_haz(input vin_t v);
        return v.mr && (v.ex_rt != 5'd0) && ((v.ex_rt == v.rs) || (v.ex_rt == v.rt));
    endfunction

    function automatic logic [6:0] model_en(input vin_t v);
        if (m_err || (v.req && !v.rdy)) return 7'b0000000;
        if (is_haz(v))                  return 7'b0011101;
        if (v.br)                       return 7'b1111110;
        return 7'b1111100;
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef STALL_CNT_EN
        return 32'(m_cnt);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [6:0] outs();
        return {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write,
                bus.mem_wb_write, bus.if_id_flush, bus.id_ex_flush};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input vin_t v);
        bus.id_ex_mem_read = v.mr;
        bus.id_ex_rt       = v.ex_rt;
        bus.if_id_rs       = v.rs;
        bus.if_id_rt       = v.rt;
        bus.branch_taken   = v.br;
        bus.dmem_req       = v.req;
        bus.dmem_ready     = v.rdy;
    endtask

    // Entered 1 time unit after a rising edge; returns likewise.
    task automatic step(input vin_t v, input string tag, input bit ovr, input logic [6:0] oexp);
        logic [6:0] e;
        apply(v);
        #3;
        e = model_en(v);
        check({tag, " enables"}, 32'(outs()), ovr ? 32'(oexp) : 32'(e));
        check({tag, " bus_err"}, 32'(bus.bus_err), 32'(m_err));
        check({tag, " stall_cycles"}, 32'(bus.stall_cycles), exp_cnt());
        @(posedge clk);
        if (!m_err) begin
            if (!e[6] && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (v.req && !v.rdy) begin
                m_wait++;
                if (m_wait >= MW) m_err = 1'b1;
            end else begin
                m_wait = 0;
            end
        end
        #1;
    endtask

    // Asserts reset away from a clock edge and checks outputs fall at once.
    task automatic do_reset(input string tag);
        apply(mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0));
        rst = 1'b0;
        #1;
        check({tag, " enables"}, 32'(outs()), 32'd0);
        check({tag, " bus_err"}, 32'(bus.bus_err), 32'd0);
        check({tag, " stall_cycles"}, 32'(bus.stall_cycles), 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_wait = 0;
        m_err  = 1'b0;
        m_cnt  = '0;
    endtask

    vec_t tbl[13];

    initial begin
        vin_t        v;
        vin_t        idle;
        logic [15:0] cnt0;

        idle = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        tbl[0]  = '{mk(1, 5, 5, 0, 0, 0, 0), 7'b0011101};  // load-use via rs
        tbl[1]  = '{mk(1, 5, 0, 5, 0, 0, 0), 7'b0011101};  // load-use via rt
        tbl[2]  = '{mk(1, 0, 0, 0, 0, 0, 0), 7'b1111100};  // r0 never hazards
        tbl[3]  = '{mk(0, 5, 5, 0, 0, 0, 0), 7'b1111100};  // not a load
        tbl[4]  = '{mk(1, 7, 3, 4, 1, 0, 0), 7'b1111110};  // branch only
        tbl[5]  = '{mk(1, 5, 5, 0, 1, 0, 0), 7'b0011101};  // hazard beats branch
        tbl[6]  = '{mk(0, 0, 0, 0, 1, 1, 1), 7'b1111110};  // ready access + branch
        tbl[7]  = '{mk(1, 5, 5, 0, 1, 1, 0), 7'b0000000};  // memory stall wins
        tbl[8]  = '{mk(1, 9, 0, 9, 0, 0, 0), 7'b0011101};  // req dropped in wait
        tbl[9]  = '{mk(0, 0, 0, 0, 0, 1, 1), 7'b1111100};
        tbl[10] = '{mk(0, 0, 0, 0, 0, 1, 0), 7'b0000000};
        tbl[11] = '{mk(0, 0, 0, 0, 0, 1, 0), 7'b0000000};
        tbl[12] = '{mk(0, 0, 0, 0, 1, 1, 1), 7'b1111110};  // ready in wait + branch

        do_reset("reset");

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].in, $sformatf("vec%0d", i), 1'b1, tbl[i].exp);
        end

        // Three wait cycles, then ready.
        cnt0 = m_cnt;
        for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 0, 1, 0), "memwait3", 1'b1, 7'b0000000);
        step(mk(0, 0, 0, 0, 0, 1, 1), "memwait3 ready", 1'b1, 7'b1111100);
        step(idle, "memwait3 after", 1'b1, 7'b1111100);
`ifdef STALL_CNT_EN
        check("memwait3 stall_cycles", 32'(bus.stall_cycles), 32'(cnt0 + 16'd3));
`else
        check("memwait3 stall_cycles", 32'(bus.stall_cycles), 32'd0);
`endif

        // All three hazards at once: memory first, then load-use, then branch.
        step(mk(1, 5, 5, 0, 1, 1, 0), "prio mem", 1'b1, 7'b0000000);
        step(mk(1, 5, 5, 0, 1, 1, 1), "prio hazard", 1'b1, 7'b0011101);
        step(mk(0, 0, 5, 0, 1, 0, 0), "prio branch", 1'b1, 7'b1111110);

        // Asynchronous reset in the middle of a memory wait.
        step(mk(0, 0, 0, 0, 0, 1, 0), "midwait", 1'b1, 7'b0000000);
        step(mk(0, 0, 0, 0, 0, 1, 0), "midwait", 1'b1, 7'b0000000);
        do_reset("midwait reset");
        step(idle, "after reset", 1'b1, 7'b1111100);

        // Timeout: ERROR after MW stalled cycles, sticky until reset.
        for (int i = 0; i < MW; i++) step(mk(0, 0, 0, 0, 0, 1, 0), "timeout", 1'b1, 7'b0000000);
        check("timeout bus_err", 32'(bus.bus_err), 32'd1);
        step(mk(0, 0, 0, 0, 1, 1, 1), "error sticky", 1'b1, 7'b0000000);
        step(idle, "error sticky", 1'b1, 7'b0000000);
        check("error bus_err held", 32'(bus.bus_err), 32'd1);
        do_reset("error reset");
        step(idle, "after error reset", 1'b1, 7'b1111100);

        // Randomized phases; the last one keeps requests pending to reach ERROR.
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 150; i++) begin
                v = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)),
                       (ph == 3) ? 1'b1 : 1'($urandom_range(0, 1)),
                       (ph == 3) ? ($urandom_range(0, 15) == 0) : 1'($urandom_range(0, 1)));
                step(v, $sformatf("rand%0d.%0d", ph, i), 1'b0, 7'b0);
            end
            do_reset($sformatf("rand%0d reset", ph));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
